// File: rtl/booth_seq_mult_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier:
// digit and state encodings, width derivations and the window decoder.
package booth_seq_mult_pkg;

   localparam int DEF_WIDTH = 12;

   typedef enum logic [2:0] {
      BOOTH_Z,
      BOOTH_P1,
      BOOTH_P2,
      BOOTH_M1,
      BOOTH_M2
   } booth_digit_t;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   function automatic int pw_of(input int w);
      return 2 * w;
   endfunction

   function automatic int ndig_of(input int w);
      return w / 2;
   endfunction

   // Window is {a[2i+1], a[2i], a[2i-1]}.
   function automatic booth_digit_t booth_decode(input logic [2:0] win);
      booth_digit_t d;
      case (win)
         3'b001, 3'b010: d = BOOTH_P1;
         3'b011:         d = BOOTH_P2;
         3'b100:         d = BOOTH_M2;
         3'b101, 3'b110: d = BOOTH_M1;
         default:        d = BOOTH_Z;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Radix-4 Booth partial-product generator: decodes one 3-bit window and returns
// digit*b, sign-extended to 2*WIDTH and shifted left by 2*i.
module booth_r4_pp
   import booth_seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SW    = 3
) (
   input  logic [2:0]         i_window,
   input  logic [WIDTH-1:0]   i_b,
   input  logic [SW-1:0]      i_shift,
   output logic [2*WIDTH-1:0] o_pp
);

   localparam int PW = pw_of(WIDTH);

   booth_digit_t w_digit;
   logic [PW-1:0] w_b_ext;
   logic [PW-1:0] w_b_neg;
   logic [PW-1:0] w_mag;

   assign w_digit = booth_decode(i_window);
   assign w_b_ext = {{WIDTH{i_b[WIDTH-1]}}, i_b};
   // Negate at full product width so that -(-2^(WIDTH-1)) does not overflow.
   assign w_b_neg = ~w_b_ext + PW'(1);

   always_comb begin
      w_mag = '0;
      case (w_digit)
         BOOTH_P1: w_mag = w_b_ext;
         BOOTH_P2: w_mag = w_b_ext << 1;
         BOOTH_M1: w_mag = w_b_neg;
         BOOTH_M2: w_mag = w_b_neg << 1;
         default:  w_mag = '0;
      endcase
   end

   assign o_pp = w_mag << {i_shift, 1'b0};

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit per clock,
// WIDTH/2 cycles from accepted start to a one-cycle done pulse.
module booth_seq_mult
   import booth_seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   mult_a,
   input  logic [WIDTH-1:0]   mult_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               dbg_state
);

   // Handshake: start is sampled only while busy=0; done pulses for exactly one
   // cycle with product valid, and product holds until the next completion.

   localparam int PW   = pw_of(WIDTH);
   localparam int NDIG = ndig_of(WIDTH);
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t            r_state;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [PW-1:0]     r_acc;
   logic [PW-1:0]     r_product;
   logic [CW-1:0]     r_cnt;
   logic              r_busy;
   logic              r_done;

   logic [WIDTH:0]    w_a_ext;
   logic [2:0]        w_window;
   logic [PW-1:0]     w_pp;
   logic [PW-1:0]     w_acc_next;

   // Appended zero plays the role of a[-1] for the first window.
   assign w_a_ext    = {r_a, 1'b0};
   assign w_window   = w_a_ext[{r_cnt, 1'b0} +: 3];
   assign w_acc_next = r_acc + w_pp;

   booth_r4_pp #(
      .WIDTH (WIDTH),
      .SW    (CW)
   ) u_pp (
      .i_window (w_window),
      .i_b      (r_b),
      .i_shift  (r_cnt),
      .o_pp     (w_pp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_product <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= mult_a;
                  r_b     <= mult_b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (r_cnt == CW'(NDIG - 1)) begin
                  r_product <= w_acc_next;
                  r_acc     <= w_acc_next;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= ST_IDLE;
               end else begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign product   = r_product;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult: stimulus pushes expected products into a
// queue, an independent monitor pops and compares on every done pulse.
module tb_booth_seq_mult;

   localparam int W  = 12;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  mult_a;
   logic [W-1:0]  mult_b;
   logic          busy;
   logic          done;
   logic [PW-1:0] product;
   logic          dbg_state;

   logic [PW-1:0] exp_q[$];
   int            errors    = 0;
   int            checks    = 0;
   int            done_cnt  = 0;
   int            n_issued  = 0;
   logic          prev_done = 1'b0;

   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [PW-1:0] p;
   } vec_t;

   vec_t vecs [11];

   booth_seq_mult #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mult_a    (mult_a),
      .mult_b    (mult_b),
      .busy      (busy),
      .done      (done),
      .product   (product),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [PW-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [PW-1:0] sa;
      logic signed [PW-1:0] sb;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got product %h expected no done", product);
         end else begin
            check("product", product, exp_q.pop_front());
         end
         check("done_one_cycle", {23'd0, prev_done}, 24'd0);
      end
      prev_done = done;
   end

   // ---------------- driver tasks ----------------
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [PW-1:0] p);
      int cyc;
      int busy_cyc;
      @(negedge clk);
      mult_a = a;
      mult_b = b;
      start  = 1'b1;
      exp_q.push_back(p);
      n_issued++;
      cyc      = 0;
      busy_cyc = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (busy) busy_cyc++;
      end while (!done && cyc < 20);
      check("latency", PW'(cyc - 1), PW'(W / 2));
      check("busy_cycles", PW'(busy_cyc), PW'(W / 2));
      @(negedge clk);
      check("product_hold", product, p);
      check("done_low_after", {23'd0, done}, 24'd0);
   endtask

   task automatic wait_done(input string name, output int cyc);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) check(name, 24'd0, 24'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vecs = '{
         '{12'h003, 12'h005, 24'h00000F},
         '{12'h800, 12'h800, 24'h400000},
         '{12'h800, 12'h7FF, 24'hC00800},
         '{12'h000, 12'hFFF, 24'h000000},
         '{12'h7FF, 12'h7FF, 24'h3FF001},
         '{12'hFFF, 12'h7FF, 24'hFFF801},
         '{12'h555, 12'h002, 24'h000AAA},
         '{12'hAAA, 12'h003, 24'hFFEFFE},
         '{12'h800, 12'h001, 24'hFFF800},
         '{12'h001, 12'h800, 24'hFFF800},
         '{12'hFFF, 12'hFFF, 24'h000001}
      };

      rst    = 1'b1;
      start  = 1'b0;
      mult_a = '0;
      mult_b = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {23'd0, busy}, 24'd0);
      check("reset_done", {23'd0, done}, 24'd0);
      check("reset_product", product, 24'd0);
      check("reset_state", {23'd0, dbg_state}, 24'd0);
      rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

      // start held high through the op, operands changed mid-op; second op
      // is accepted in the done cycle with the new operands.
      @(negedge clk);
      mult_a = 12'h007;
      mult_b = 12'h009;
      start  = 1'b1;
      exp_q.push_back(24'h00003F);
      n_issued++;
      repeat (2) @(negedge clk);
      mult_a = 12'hFFB;
      mult_b = 12'h006;
      exp_q.push_back(24'hFFFFE2);
      n_issued++;
      wait_done("b2b_first_timeout", cyc);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", {23'd0, busy}, 24'd1);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < 20);
      check("b2b_latency", PW'(cyc), PW'(W / 2));
      repeat (2) @(negedge clk);

      // Reset mid-op: no done and all outputs cleared.
      mult_a = 12'd100;
      mult_b = 12'hFFD;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {23'd0, busy}, 24'd0);
      check("abort_done", {23'd0, done}, 24'd0);
      check("abort_product", product, 24'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      run_op(12'hFFF, 12'hFFF, 24'h000001);

      for (int k = 0; k < 40; k++) begin
         ra = W'($urandom_range(0, (1 << W) - 1));
         rb = W'($urandom_range(0, (1 << W) - 1));
         run_op(ra, rb, golden(ra, rb));
      end

      repeat (3) @(negedge clk);
      check("done_count", PW'(done_cnt), PW'(n_issued));
      check("queue_empty", PW'(exp_q.size()), 24'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
